id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Sits between decode/controller and execute.
- Captures decoded control fields, register-file operands, immediate and PC each cycle; presents them registered to the EX stage, which includes the ALU operation decoder and the ALU.
- Inserts bubbles on load-use hazards and branch flushes; freezes on downstream hold.

Parameters:
DATA_W, 32, operand/immediate width
PC_W, 9, program counter width
REG_AW, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
id_valid  in  1  decode slot holds a real instruction
id_ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
id_Funct3  in  3  instruction bits 14:12
id_Funct7  in  7  instruction bits 31:25
id_ALUSrc, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_Branch  in  1 each  decode control bits
id_rs1, id_rs2, id_rd  in  REG_AW each  register indices
id_rd1, id_rd2, id_imm  in  DATA_W each  operands, sign-extended immediate
id_pc  in  PC_W  instruction PC
flush  in  1  branch/jump taken in EX; kill instruction in ID
hold  in  1  downstream (MEM) stall; freeze EX register
stall  out  1  to PC/IF-ID: hold fetch and decode this cycle
ex_valid  out  1  registered id_valid
ex_ALUOp, ex_Funct3, ex_Funct7, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc  out  matching widths  registered copies

Behaviour:
- All ex_* outputs are registers. Reset value is 0 for every ex_* output, including ex_valid=0 and ex_ALUOp=00.
- Bubble = ex_valid=0 and all control bits 0 (ALUOp=00, MemRead/MemWrite/RegWrite/Branch/MemtoReg/ALUSrc=0). Data/index fields hold their previous values in a bubble.
- Load-use hazard, combinational: haz = ex_valid & ex_MemRead & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
- stall = hold | (haz & ~flush). Combinational, zero-cycle.
- Per-edge priority:
  1. reset: all zero.
  2. hold: every ex_* register keeps its value. flush is ignored; upstream keeps flush asserted until hold deasserts.
  3. flush: load a bubble.
  4. haz: load a bubble. ID is held by stall, so the same instruction is re-presented next cycle and captured then, giving a 1-cycle penalty.
  5. Otherwise: capture all id_* fields.
- Capture rule: ex_RegWrite <= id_RegWrite & (id_rd!=0). Writes to x0 never propagate.
- If id_valid=0, capture a bubble.
- Latency: exactly 1 cycle from ID to EX when no event is active.
- Back-to-back loads feeding dependents: each dependent stalls exactly once.
- flush and haz together: flush wins and stall is 0, because the dependent is killed.
- reset asserted mid-stall or mid-hold: next cycle is all zero and stall=0.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined, adds these outputs, both reset to 0, saturating at all-ones:
  - bubble_cnt (32 bits): +1 per cycle a haz bubble is inserted.
  - flush_cnt (32 bits): +1 per cycle a flush bubble is inserted.
  - Neither counter increments while hold=1.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: pulse reset for 2 cycles with random id_* inputs -> all ex_*=0, stall=0.
- Pass-through: id_valid=1, ALUOp=10, Funct3=000, Funct7=0100000, rd=5, rd1=0x10, rd2=0x3 -> next cycle ex_* identical, ex_RegWrite=1, stall=0.
- Load-use: EX holds LW with rd=7; ID instruction has rs2=7 -> stall=1 for 1 cycle, EX gets bubble (ex_valid=0, ex_ALUOp=00); next cycle dependent captured, stall=0. Repeat with rd=0 -> no stall.
- Flush: assert flush with a valid ID instruction, and again while haz=1 -> EX bubble, stall=0, ex_RegWrite=0.
- Hold: hold=1 for 3 cycles with changing id_* and flush pulsed -> ex_* unchanged, stall=1 each cycle. Release hold -> flush honoured.
- x0 write and counters: id_rd=0, id_RegWrite=1 -> ex_RegWrite=0. With ID_EX_PERF_CNT_EN defined, 2 haz bubbles and 1 flush -> bubble_cnt=2, flush_cnt=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register with integrated load-use hazard detection. Decoded
// control fields, register-file operands, immediate and PC from decode are
// registered here and presented to the execute stage one cycle later.
//
// Event priority on each rising edge:
//   reset > hold (freeze) > flush (bubble) > load-use hazard (bubble) > capture
//
// A bubble clears ex_valid and every control bit. The data and index fields
// keep their previous values because nothing downstream consumes them while
// ex_valid is low.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   id_*                decode-stage instruction fields and operands
//   flush               branch/jump taken in EX: kill the instruction in ID
//   hold                downstream stall: freeze the EX register
//   stall               combinational request to hold PC and IF/ID this cycle
//   ex_*                registered copies of the id_* fields
//
// Optional feature (macro ID_EX_PERF_CNT_EN):
//   bubble_cnt          saturating count of load-use bubbles inserted
//   flush_cnt           saturating count of flush bubbles inserted
//   Neither counter advances while hold is high.
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [1:0]        id_ALUOp,
    input  logic [2:0]        id_Funct3,
    input  logic [6:0]        id_Funct7,
    input  logic              id_ALUSrc,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_RegWrite,
    input  logic              id_MemtoReg,
    input  logic              id_Branch,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [PC_W-1:0]   id_pc,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic              ex_valid,
    output logic [1:0]        ex_ALUOp,
    output logic [2:0]        ex_Funct3,
    output logic [6:0]        ex_Funct7,
    output logic              ex_ALUSrc,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_RegWrite,
    output logic              ex_MemtoReg,
    output logic              ex_Branch,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [PC_W-1:0]   ex_pc
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    // A load in EX whose destination is read by the instruction in ID cannot
    // forward in time; the dependent must wait one cycle. x0 never hazards.
    logic haz;
    logic load_bubble;

    assign haz = ex_valid & ex_MemRead & (ex_rd != '0) & id_valid &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // A flush kills the dependent, so there is nothing to hold in ID for it.
    assign stall = hold | (haz & ~flush);

    assign load_bubble = flush | haz | ~id_valid;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: data fields are reset as well so the whole EX register has
            // a defined value out of reset, not just the control bits.
            ex_valid    <= 1'b0;
            ex_ALUOp    <= '0;
            ex_Funct3   <= '0;
            ex_Funct7   <= '0;
            ex_ALUSrc   <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
        end else if (!hold) begin
            if (load_bubble) begin
                ex_valid    <= 1'b0;
                ex_ALUOp    <= '0;
                ex_Funct3   <= '0;
                ex_Funct7   <= '0;
                ex_ALUSrc   <= 1'b0;
                ex_MemRead  <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_MemtoReg <= 1'b0;
                ex_Branch   <= 1'b0;
            end else begin
                ex_valid    <= 1'b1;
                ex_ALUOp    <= id_ALUOp;
                ex_Funct3   <= id_Funct3;
                ex_Funct7   <= id_Funct7;
                ex_ALUSrc   <= id_ALUSrc;
                ex_MemRead  <= id_MemRead;
                ex_MemWrite <= id_MemWrite;
                // Writes to x0 are dropped here so later stages never see them.
                ex_RegWrite <= id_RegWrite & (id_rd != '0);
                ex_MemtoReg <= id_MemtoReg;
                ex_Branch   <= id_Branch;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rd       <= id_rd;
                ex_rd1      <= id_rd1;
                ex_rd2      <= id_rd2;
                ex_imm      <= id_imm;
                ex_pc       <= id_pc;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Flush takes precedence over the hazard, so a cycle counts in one place only.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (!hold) begin
            if (flush) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
            end else if (haz) begin
                if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. A transaction-level model holds the
// expected EX contents as one record and advances it once per clock from the
// event priority rules. A single compare process checks every EX field shortly
// after each rising edge and the combinational stall at each falling edge.
// A directed prologue pins the model with hand-computed values; a randomized
// phase then exercises hazards, flushes, holds and resets together.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        alusrc;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
        logic        br;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [8:0]  pc;
    } stage_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   hold;
    logic   flush;
    stage_t id;

    logic        stall;
    logic        ex_valid;
    logic [1:0]  ex_ALUOp;
    logic [2:0]  ex_Funct3;
    logic [6:0]  ex_Funct7;
    logic        ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rd1, ex_rd2, ex_imm;
    logic [8:0]  ex_pc;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id.v), .id_ALUOp(id.aluop), .id_Funct3(id.f3), .id_Funct7(id.f7),
        .id_ALUSrc(id.alusrc), .id_MemRead(id.mr), .id_MemWrite(id.mw),
        .id_RegWrite(id.rw), .id_MemtoReg(id.m2r), .id_Branch(id.br),
        .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
        .id_rd1(id.rd1), .id_rd2(id.rd2), .id_imm(id.imm), .id_pc(id.pc),
        .flush(flush), .hold(hold), .stall(stall),
        .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp), .ex_Funct3(ex_Funct3), .ex_Funct7(ex_Funct7),
        .ex_ALUSrc(ex_ALUSrc), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc(ex_pc)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    stage_t      m;          // expected EX contents
    logic [31:0] exp_bub;
    logic [31:0] exp_fl;
    bit          stall_prev; // stall the model predicted for the cycle just ended

    function automatic bit load_use(input stage_t ex, input stage_t d);
        return ex.v && ex.mr && ex.rd != 0 && d.v && (ex.rd == d.rs1 || ex.rd == d.rs2);
    endfunction

    function automatic stage_t next_ex(input stage_t ex, input stage_t d,
                                       input bit rst, input bit hld, input bit fl);
        stage_t n;
        if (rst) begin
            n = '0;
        end else if (hld) begin
            n = ex;
        end else if (fl || load_use(ex, d) || !d.v) begin
            // keep data/index fields, clear validity and all control
            n = ex;
            n.v = 0; n.aluop = 0; n.f3 = 0; n.f7 = 0;
            n.alusrc = 0; n.mr = 0; n.mw = 0; n.rw = 0; n.m2r = 0; n.br = 0;
        end else begin
            n = d;
            n.rw = d.rw && (d.rd != 0);
        end
        return n;
    endfunction

    task automatic compare_all();
        check("ex_valid", 64'(ex_valid), 64'(m.v));
        check("ex_ctrl",
              64'({ex_ALUOp, ex_Funct3, ex_Funct7, ex_ALUSrc, ex_MemRead, ex_MemWrite,
                   ex_RegWrite, ex_MemtoReg, ex_Branch}),
              64'({m.aluop, m.f3, m.f7, m.alusrc, m.mr, m.mw, m.rw, m.m2r, m.br}));
        check("ex_idx", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m.rs1, m.rs2, m.rd}));
        check("ex_rd1", 64'(ex_rd1), 64'(m.rd1));
        check("ex_rd2", 64'(ex_rd2), 64'(m.rd2));
        check("ex_imm", 64'(ex_imm), 64'(m.imm));
        check("ex_pc",  64'(ex_pc),  64'(m.pc));
`ifdef ID_EX_PERF_CNT_EN
        check("bubble_cnt", 64'(bubble_cnt), 64'(exp_bub));
        check("flush_cnt",  64'(flush_cnt),  64'(exp_fl));
`endif
    endtask

    // single compare process: model step + EX check after the edge,
    // stall check at the falling edge once inputs have settled
    initial begin
        m = '0; exp_bub = 0; exp_fl = 0; stall_prev = 0;
        forever begin
            @(posedge clk);
            stall_prev = hold | (load_use(m, id) & ~flush);
            if (reset) begin
                exp_bub = 0; exp_fl = 0;
            end else if (!hold) begin
                if (flush) begin
                    if (exp_fl != 32'hFFFF_FFFF) exp_fl = exp_fl + 1;
                end else if (load_use(m, id)) begin
                    if (exp_bub != 32'hFFFF_FFFF) exp_bub = exp_bub + 1;
                end
            end
            m = next_ex(m, id, reset, hold, flush);
            #1;
            compare_all();
            @(negedge clk);
            check("stall", 64'(stall), 64'(hold | (load_use(m, id) & ~flush)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic stage_t rand_id();
        stage_t s;
        s.v      = ($urandom_range(0, 7) != 0);
        s.aluop  = 2'($urandom);
        s.f3     = 3'($urandom);
        s.f7     = 7'($urandom);
        s.alusrc = 1'($urandom);
        s.mr     = ($urandom_range(0, 2) == 0);
        s.mw     = 1'($urandom);
        s.rw     = 1'($urandom);
        s.m2r    = 1'($urandom);
        s.br     = 1'($urandom);
        s.rs1    = 5'($urandom_range(0, 3));
        s.rs2    = 5'($urandom_range(0, 3));
        s.rd     = 5'($urandom_range(0, 3));
        s.rd1    = $urandom;
        s.rd2    = $urandom;
        s.imm    = $urandom;
        s.pc     = 9'($urandom);
        return s;
    endfunction

    function automatic stage_t instr(input logic [1:0] aluop, input bit mr,
                                     input int rs1, input int rs2, input int rd);
        stage_t s = '0;
        s.v = 1; s.aluop = aluop; s.mr = mr; s.m2r = mr; s.alusrc = mr; s.rw = 1;
        s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
        s.rd1 = 32'h100 + 32'(rd); s.rd2 = 32'h200 + 32'(rd); s.imm = 32'h4;
        s.pc = 9'(4 * rd);
        return s;
    endfunction

    initial begin
        hold = 0; flush = 0; reset = 1; id = rand_id();

        // reset with random inputs for two cycles
        tick(); id = rand_id();
        tick();
        reset = 0; id = '0;
        #1;
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_rd1",   64'(ex_rd1),   64'd0);
        check("rst_pc",    64'(ex_pc),    64'd0);
        check("rst_stall", 64'(stall),    64'd0);

        // pass-through of an R-type
        id = instr(2'b10, 0, 1, 2, 5);
        id.f7 = 7'b0100000; id.rd1 = 32'h10; id.rd2 = 32'h3;
        tick();
        check("pt_valid", 64'(ex_valid),    64'd1);
        check("pt_aluop", 64'(ex_ALUOp),    64'd2);
        check("pt_f7",    64'(ex_Funct7),   64'h20);
        check("pt_rd",    64'(ex_rd),       64'd5);
        check("pt_rd1",   64'(ex_rd1),      64'h10);
        check("pt_rw",    64'(ex_RegWrite), 64'd1);
        check("pt_stall", 64'(stall),       64'd0);

        // load-use: LW x7 then a consumer of x7 through rs2
        id = instr(2'b00, 1, 1, 2, 7);
        tick();
        id = instr(2'b10, 0, 3, 7, 8);
        #1 check("lu_stall", 64'(stall), 64'd1);
        tick();
        check("lu_bub_valid", 64'(ex_valid), 64'd0);
        check("lu_bub_aluop", 64'(ex_ALUOp), 64'd0);
        check("lu_bub_rd",    64'(ex_rd),    64'd7);
        check("lu_stall_rel", 64'(stall),    64'd0);
        tick();
        check("lu_dep_valid", 64'(ex_valid), 64'd1);
        check("lu_dep_rd",    64'(ex_rd),    64'd8);

        // load to x0: no write, no hazard
        id = instr(2'b00, 1, 1, 2, 0);
        tick();
        check("x0_rw", 64'(ex_RegWrite), 64'd0);
        check("x0_mr", 64'(ex_MemRead),  64'd1);
        id = instr(2'b10, 0, 0, 0, 6);
        #1 check("x0_stall", 64'(stall), 64'd0);
        tick();
        check("x0_dep_valid", 64'(ex_valid), 64'd1);

        // flush of a valid instruction
        id = instr(2'b10, 0, 1, 2, 4);
        flush = 1;
        #1 check("fl_stall", 64'(stall), 64'd0);
        tick();
        check("fl_valid", 64'(ex_valid),    64'd0);
        check("fl_rw",    64'(ex_RegWrite), 64'd0);
        flush = 0;

        // flush together with a load-use hazard
        id = instr(2'b00, 1, 1, 2, 7);
        tick();
        id = instr(2'b10, 0, 7, 1, 9);
        flush = 1;
        #1 check("flhz_stall", 64'(stall), 64'd0);
        tick();
        check("flhz_valid", 64'(ex_valid),    64'd0);
        check("flhz_rw",    64'(ex_RegWrite), 64'd0);
        flush = 0;

        // second load-use bubble
        id = instr(2'b00, 1, 1, 2, 9);
        tick();
        id = instr(2'b10, 0, 9, 1, 10);
        #1 check("lu2_stall", 64'(stall), 64'd1);
        tick();
        tick();
        check("lu2_rd", 64'(ex_rd), 64'd10);

        // hold for three cycles with changing inputs and a flush pulse
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            id = rand_id();
            flush = (i == 1);
            #1 check("hold_stall", 64'(stall), 64'd1);
            tick();
            check("hold_rd",    64'(ex_rd),    64'd10);
            check("hold_valid", 64'(ex_valid), 64'd1);
        end
        hold = 0; flush = 1;
        tick();
        check("hold_rel_flush", 64'(ex_valid), 64'd0);
        flush = 0;
`ifdef ID_EX_PERF_CNT_EN
        check("cnt_bubble", 64'(bubble_cnt), 64'd2);
        check("cnt_flush",  64'(flush_cnt),  64'd3);
`endif

        // reset while a hazard stall is pending
        id = instr(2'b00, 1, 1, 2, 7);
        tick();
        id = instr(2'b10, 0, 7, 2, 3);
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("rst_mid_valid", 64'(ex_valid), 64'd0);
        check("rst_mid_rd",    64'(ex_rd),    64'd0);
        check("rst_mid_stall", 64'(stall),    64'd0);

        // randomized phase; a stalled instruction is re-presented unchanged
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!stall_prev) id = rand_id();
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 199) == 0);
        end
        reset = 0; hold = 0; flush = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
